lfsr_rand_server: RTL and testbench
===================================

Name: lfsr_rand_server

Overview:
- Owns one 8-bit maximal-length LFSR and shares it between two requesters.
- Sequences seeding, warm-up stepping and per-word stepping.
- Hands each winning requester one fresh pseudo-random byte with a one-cycle grant/valid pulse.
- Sits between the LFSR datapath and consumers such as display-pattern or game-logic blocks on the board.

Parameters:
- STEPS, 8: LFSR shifts per delivered word (1..255).
- WARMUP, 16: LFSR shifts after a seed load before service resumes (0..255; 0 = none).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- seed_valid  in  1  request to load seed
- seed  in  8  seed value
- req  in  2  per-requester level request, held until granted
- gnt  out  2  one-hot grant pulse, high only in DELIVER
- rdata  out  8  random byte, valid when rvalid=1
- rvalid  out  1  one-cycle data-valid pulse, coincident with gnt
- busy  out  1  high in any state other than IDLE

Behaviour:
Reset (rst=1 at edge):
- lfsr=8'h01, state=IDLE, rr_ptr=0, cnt=0.
- gnt=2'b00, rvalid=0, rdata=8'h00, busy=0.
- rst overrides everything, including mid-GEN or mid-WARM; no partial delivery follows.

LFSR step:
- lfsr_next = {fb, lfsr[7:1]}, fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[4] (x^8+x^6+x^5+x^4+1, period 255).
- Steps occur only in GEN and WARM; otherwise lfsr holds.
- Lock-up guard: if lfsr==0 at any edge, load 8'h01 instead of stepping.

States: IDLE, WARM, GEN, DELIVER. All outputs are registered.

IDLE:
- seed_valid=1 has priority over req.
  - Load lfsr = (seed==0) ? 8'h01 : seed.
  - If WARMUP>0: cnt=WARMUP-1, go WARM. Else stay IDLE.
- Else if req!=0, pick the winner:
  - If both requesters are asserted, the winner is requester rr_ptr.
  - Otherwise the winner is the single asserted requester.
  - Latch the winner, set cnt=STEPS-1, go GEN.

WARM:
- Step each cycle.
- When cnt==0, go IDLE; else cnt-1.
- seed_valid and req are ignored; req stays pending.

GEN:
- Step each cycle.
- When cnt==0, go DELIVER; else cnt-1.
- New seed_valid is ignored. A requester deasserting req does not abort the word.

DELIVER (exactly one cycle):
- rdata = lfsr (value after STEPS steps), rvalid=1, gnt[winner]=1.
- rr_ptr = ~winner. Go IDLE.
- rdata holds its last value outside DELIVER.

Latency and throughput:
- A req sampled at edge E yields rvalid high in the cycle after edge E+STEPS.
- Sustained throughput: one word per STEPS+2 cycles.
- Requester must drop req after seeing gnt, or it is treated as a new request on the next IDLE sample.

Fairness:
- With both requesters held asserted, grants alternate strictly: 0,1,0,1…
- A single requester is served back-to-back.

Test Plan:
1. Reset, then req=2'b01 held one cycle at edge E (STEPS=8) -> gnt=2'b01, rvalid=1, rdata=8'h71 in the cycle after edge E+8; intermediate lfsr 80,40,20,10,88,C4,E2,71; busy high throughout GEN/DELIVER.
2. seed_valid=1 with seed=8'h00, WARMUP=0, then req=2'b10 -> seed treated as 8'h01; gnt=2'b10, rdata=8'h71.
3. req=2'b11 held for 4 words after reset -> gnt sequence 01,10,01,10; each word differs and matches the software LFSR model; no grant ever has two bits set.
4. seed_valid=1 during GEN, and req asserted during WARM (WARMUP=16) -> seed ignored in GEN; pending req is accepted only on the first IDLE after WARM completes 16 steps.
5. rst asserted mid-GEN (cycle 3 of 8) -> next cycle: state IDLE, lfsr=8'h01, gnt=0, rvalid=0, rdata=8'h00; no delivery follows.
6. STEPS=1, single requester, 256 consecutive words -> first 255 values distinct and nonzero; word 256 equals word 1.

Source files
------------

// File: rtl/lfsr_rand_server.sv
// Shared 8-bit maximal-length LFSR that serves one fresh random byte per grant
// to two requesters, with seeding, warm-up stepping and round-robin arbitration.
module lfsr_rand_server #(
  parameter int STEPS  = 8,
  parameter int WARMUP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_valid,
  input  logic [7:0] seed,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WARM, GEN, DELIVER} state_t;

  localparam logic [7:0] STEPS_M1  = 8'(STEPS - 1);
  localparam logic [7:0] WARMUP_M1 = 8'(WARMUP - 1);

  state_t     state, state_nx;
  logic [7:0] lfsr, lfsr_nx;
  logic [7:0] cnt, cnt_nx;
  logic       rr_ptr, rr_nx;
  logic       winner, winner_nx;

  logic [1:0] gnt_nx;
  logic [7:0] rdata_nx;
  logic       rvalid_nx;
  logic       busy_nx;

  // x^8+x^6+x^5+x^4+1, right-shifting Fibonacci form
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
  endfunction

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lfsr   <= 8'h01;
      cnt    <= '0;
      rr_ptr <= 1'b0;
      winner <= 1'b0;
    end else begin
      state  <= state_nx;
      lfsr   <= lfsr_nx;
      cnt    <= cnt_nx;
      rr_ptr <= rr_nx;
      winner <= winner_nx;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_nx  = state;
    lfsr_nx   = lfsr;
    cnt_nx    = cnt;
    rr_nx     = rr_ptr;
    winner_nx = winner;
    unique case (state)
      IDLE: begin
        if (seed_valid) begin
          lfsr_nx = (seed == 8'h00) ? 8'h01 : seed;
          if (WARMUP > 0) begin
            cnt_nx   = WARMUP_M1;
            state_nx = WARM;
          end
        end else if (req != 2'b00) begin
          winner_nx = (req == 2'b11) ? rr_ptr : req[1];
          cnt_nx    = STEPS_M1;
          state_nx  = GEN;
        end
      end
      WARM: begin
        lfsr_nx = lfsr_step(lfsr);
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 8'd1;
      end
      GEN: begin
        lfsr_nx = lfsr_step(lfsr);
        if (cnt == '0) state_nx = DELIVER;
        else           cnt_nx   = cnt - 8'd1;
      end
      DELIVER: begin
        rr_nx    = ~winner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // an all-zero register would never leave zero; recover instead of stepping
    if (lfsr == 8'h00) lfsr_nx = 8'h01;
  end

  // outputs are computed from the upcoming state so they register in step with it
  always_comb begin
    gnt_nx    = 2'b00;
    rvalid_nx = 1'b0;
    rdata_nx  = rdata;
    busy_nx   = (state_nx != IDLE);
    if (state_nx == DELIVER) begin
      gnt_nx[winner_nx] = 1'b1;
      rvalid_nx         = 1'b1;
      rdata_nx          = lfsr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= 2'b00;
      rvalid <= 1'b0;
      rdata  <= 8'h00;
      busy   <= 1'b0;
    end else begin
      gnt    <= gnt_nx;
      rvalid <= rvalid_nx;
      rdata  <= rdata_nx;
      busy   <= busy_nx;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Scoreboard bench for lfsr_rand_server: three instances with different
// STEPS/WARMUP; stimulus pushes expected words, a negedge monitor checks them.
module tb_lfsr_rand_server;

  logic            clk;
  logic [2:0]      rst_a, sv_a, rvalid_a, busy_a;
  logic [2:0][7:0] seed_a, rdata_a;
  logic [2:0][1:0] req_a, gnt_a;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         id;
    logic [1:0] g;
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t q[$];

  logic [7:0] rx[256];
  int         rx_n = 0;

  lfsr_rand_server #(.STEPS(8), .WARMUP(16)) u0 (
    .clk(clk), .rst(rst_a[0]), .seed_valid(sv_a[0]), .seed(seed_a[0]), .req(req_a[0]),
    .gnt(gnt_a[0]), .rdata(rdata_a[0]), .rvalid(rvalid_a[0]), .busy(busy_a[0]));
  lfsr_rand_server #(.STEPS(8), .WARMUP(0)) u1 (
    .clk(clk), .rst(rst_a[1]), .seed_valid(sv_a[1]), .seed(seed_a[1]), .req(req_a[1]),
    .gnt(gnt_a[1]), .rdata(rdata_a[1]), .rvalid(rvalid_a[1]), .busy(busy_a[1]));
  lfsr_rand_server #(.STEPS(1), .WARMUP(0)) u2 (
    .clk(clk), .rst(rst_a[2]), .seed_valid(sv_a[2]), .seed(seed_a[2]), .req(req_a[2]),
    .gnt(gnt_a[2]), .rdata(rdata_a[2]), .rvalid(rvalid_a[2]), .busy(busy_a[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // software reference of the LFSR: n steps from v
  function automatic logic [7:0] stepn(input logic [7:0] v, input int n);
    logic [7:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[0] ^ x[2] ^ x[3] ^ x[4], x[7:1]};
    return x;
  endfunction

  task automatic push(input int id, input logic [1:0] g, input logic [7:0] d, input int c);
    exp_t e;
    e.id = id; e.g = g; e.d = d; e.c = c;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, need %0h", nm, act, exp);
    end
  endtask

  // monitor: every rvalid must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rvalid_a[d] === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected id=%0d: got gnt=%b data=%h at cyc %0d, need no word", d, gnt_a[d], rdata_a[d], cyc);
        end else begin
          e = q.pop_front();
          if (e.id != d || e.g !== gnt_a[d] || e.d !== rdata_a[d] || e.c != cyc) begin
            n_bad++;
            $display("FAIL sb_word: got id=%0d gnt=%b data=%h cyc=%0d, need id=%0d gnt=%b data=%h cyc=%0d",
                     d, gnt_a[d], rdata_a[d], cyc, e.id, e.g, e.d, e.c);
          end
        end
        if (d == 2 && rx_n < 256) begin
          rx[rx_n] = rdata_a[2];
          rx_n++;
        end
      end else if (gnt_a[d] !== 2'b00 && gnt_a[d] !== 2'bxx) begin
        n_cmp++;
        n_bad++;
        $display("FAIL gnt_without_rvalid id=%0d: got gnt=%b, need 00", d, gnt_a[d]);
      end
    end
  end

  task automatic do_reset(input int id);
    @(negedge clk);
    rst_a[id] = 1'b1;
    @(negedge clk);
    rst_a[id] = 1'b0;
    chk("reset_gnt", 32'(gnt_a[id]), 32'h0);
    chk("reset_rvalid", 32'(rvalid_a[id]), 32'h0);
    chk("reset_rdata", 32'(rdata_a[id]), 32'h0);
    chk("reset_busy", 32'(busy_a[id]), 32'h0);
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d words outstanding, need 0", q.size());
      q.delete();
    end
  endtask

  // keep req held until nw words have been delivered to this requester
  task automatic hold_until(input int id, input int nw, input int maxc);
    int seen = 0;
    int c = 0;
    while (seen < nw && c < maxc) begin
      @(negedge clk);
      c++;
      if (rvalid_a[id] === 1'b1) seen++;
    end
    req_a[id] = 2'b00;
    chk("hold_words", 32'(seen), 32'(nw));
  endtask

  initial begin
    int k, e;
    int nz, dup;
    logic [255:0] seen;
    rst_a = 3'b111; sv_a = '0; seed_a = '0; req_a = '0;
    repeat (2) @(negedge clk);
    rst_a = 3'b000;

    // 1: single request from reset, hand-computed word 71
    do_reset(0);
    req_a[0] = 2'b01;
    k = cyc;
    push(0, 2'b01, 8'h71, k + 9);
    @(negedge clk);
    req_a[0] = 2'b00;
    for (int i = 0; i < 9; i++) begin
      chk("busy_gen", 32'(busy_a[0]), 32'h1);
      @(negedge clk);
    end
    chk("idle_busy", 32'(busy_a[0]), 32'h0);
    @(negedge clk);
    chk("rdata_hold", 32'(rdata_a[0]), 32'h71);
    drain(20);

    // 2: zero seed maps to 01; seed has priority over a simultaneous req
    do_reset(1);
    req_a[1] = 2'b01;
    push(1, 2'b01, 8'h71, cyc + 9);
    @(negedge clk);
    req_a[1] = 2'b00;
    drain(20);
    sv_a[1] = 1'b1; seed_a[1] = 8'h00;
    @(negedge clk);
    sv_a[1] = 1'b0;
    chk("seed_nowarm_busy", 32'(busy_a[1]), 32'h0);
    req_a[1] = 2'b10;
    push(1, 2'b10, 8'h71, cyc + 9);
    @(negedge clk);
    req_a[1] = 2'b00;
    drain(20);
    sv_a[1] = 1'b1; seed_a[1] = 8'hA5; req_a[1] = 2'b01;
    push(1, 2'b01, stepn(8'hA5, 8), cyc + 10);
    @(negedge clk);
    sv_a[1] = 1'b0;
    hold_until(1, 1, 30);
    drain(20);

    // 3: both requesters held -> strict alternation 01,10,01,10
    do_reset(0);
    req_a[0] = 2'b11;
    k = cyc;
    for (int n = 0; n < 4; n++)
      push(0, (n % 2 == 0) ? 2'b01 : 2'b10, stepn(8'h01, 8 * (n + 1)), k + 1 + 10 * n + 8);
    hold_until(0, 4, 100);
    drain(20);

    // 4: req during WARM waits for the warm-up; seed during GEN is ignored
    sv_a[0] = 1'b1; seed_a[0] = 8'h5A;
    k = cyc;
    @(negedge clk);
    sv_a[0] = 1'b0;
    chk("warm_busy", 32'(busy_a[0]), 32'h1);
    @(negedge clk);
    @(negedge clk);
    req_a[0] = 2'b01;
    e = k + 18;
    push(0, 2'b01, stepn(8'h5A, 24), e + 8);
    while (cyc < e + 2) @(negedge clk);
    sv_a[0] = 1'b1; seed_a[0] = 8'h33;
    @(negedge clk);
    @(negedge clk);
    sv_a[0] = 1'b0;
    hold_until(0, 1, 40);
    drain(20);

    // 5: reset mid-GEN discards the word and restores lfsr=01
    req_a[0] = 2'b01;
    @(negedge clk);
    req_a[0] = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_a[0] = 1'b1;
    @(negedge clk);
    rst_a[0] = 1'b0;
    chk("midgen_rst_gnt", 32'(gnt_a[0]), 32'h0);
    chk("midgen_rst_rvalid", 32'(rvalid_a[0]), 32'h0);
    chk("midgen_rst_rdata", 32'(rdata_a[0]), 32'h0);
    chk("midgen_rst_busy", 32'(busy_a[0]), 32'h0);
    repeat (12) @(negedge clk);
    req_a[0] = 2'b10;
    push(0, 2'b10, 8'h71, cyc + 9);
    @(negedge clk);
    req_a[0] = 2'b00;
    drain(20);

    // 6: STEPS=1, 256 back-to-back words walk the full period
    do_reset(2);
    rx_n = 0;
    req_a[2] = 2'b01;
    k = cyc;
    for (int n = 0; n < 256; n++)
      push(2, 2'b01, stepn(8'h01, n + 1), k + 1 + 3 * n + 1);
    hold_until(2, 256, 1000);
    drain(20);
    chk("period_count", 32'(rx_n), 32'd256);
    nz = 0; dup = 0; seen = '0;
    for (int n = 0; n < 255 && n < rx_n; n++) begin
      if (rx[n] != 8'h00) nz++;
      if (seen[rx[n]]) dup++;
      seen[rx[n]] = 1'b1;
    end
    chk("period_nonzero", 32'(nz), 32'd255);
    chk("period_distinct", 32'(dup), 32'd0);
    chk("period_wrap", 32'(rx[255]), 32'(rx[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
